cpu_boot_loader: RTL and testbench
==================================

CPU_BOOT_LOADER -- requirements
Module: cpu_boot_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256: instruction-memory words; legal load lengths are 1..MEM_DEPTH.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum idle cycles allowed between accepted bytes while receiving.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a load.
REQ-006 SHALL have port in_data, input, 8: boot byte stream.
REQ-007 SHALL have ports in_valid (input, 1) and in_ready (output, 1): byte handshake; a byte is accepted on a cycle where both are high.
REQ-008 SHALL have port instruction_in, output, 16: word to the CPU instruction memory.
REQ-009 SHALL have port load_address, output, 16: write address to the CPU instruction memory.
REQ-010 SHALL have port load_instruction, output, 1: instruction-memory write strobe.
REQ-011 SHALL have port pc_reset, output, 1: active-high CPU hold; the CPU runs only while it is 0.
REQ-012 SHALL have ports busy, done and error, output, 1 each: status flags.

Function
REQ-013 SHALL implement states IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN and ERROR.
REQ-014 SHALL move from IDLE, RUN or ERROR to LEN_HI on start, reasserting pc_reset=1 and clearing done and error in that same edge.
REQ-015 SHALL ignore start in all other states.
REQ-016 SHALL drive in_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK.
REQ-017 SHALL take the stream format as: 16-bit word count N (MSB byte first), then N instruction words (high byte first).
REQ-018 SHALL go to ERROR after LEN_LO if N==0 or N>MEM_DEPTH.
REQ-019 SHALL otherwise clear the address to 0 and enter DATA_HI.
REQ-020 SHALL enter WRITE on the edge that accepts the DATA_LO byte.
REQ-021 SHALL in WRITE assert load_instruction for exactly one cycle, with instruction_in = assembled word and load_address = current address.
REQ-022 SHALL after WRITE increment the address, then go to DATA_HI if address<N, else to CHECK (macro defined) or RUN.
REQ-023 SHALL give one accepted byte per write a minimum throughput of 3 cycles per word.
REQ-024 SHALL in RUN drive pc_reset=0 and done=1, and hold there until the next start.
REQ-025 SHALL drive busy=1 in every state except IDLE, RUN and ERROR.
REQ-026 SHALL keep an idle counter that clears on each accepted byte and while not receiving.
REQ-027 SHALL go to ERROR when the idle counter reaches TIMEOUT_CYCLES in a receiving state.
REQ-028 SHALL in ERROR drive error=1 and pc_reset=1, leave already-written words in memory, and never let load_instruction pulse.
REQ-029 SHALL ignore in_data outside handshake cycles; only accepted bytes advance the state.

Reset
REQ-030 SHALL while reset_n=0, independent of clk: state=IDLE, pc_reset=1, load_instruction=0, instruction_in=0, load_address=0, in_ready=0, busy=0, done=0, error=0, counters 0.
REQ-031 SHALL abandon a load on reset mid-operation, with no further strobes and the CPU held.

Configuration
REQ-032 SHALL use macro BOOT_CHECKSUM_EN to compile the checksum stage in or out.
REQ-033 SHALL when BOOT_CHECKSUM_EN is defined: after the last word, accept one byte in CHECK, going to RUN if it equals the XOR of all preceding stream bytes including length, else to ERROR.
REQ-034 SHALL when BOOT_CHECKSUM_EN is undefined: omit CHECK, with WRITE going directly to RUN after the last word.

Verification
REQ-035 SHALL cover: start, stream 00 02 12 34 AB CD -> strobes at addr 0 with 0x1234 and addr 1 with 0xABCD, then pc_reset=0 and done=1.
REQ-036 SHALL cover: length bytes 00 00 or 01 01 (MEM_DEPTH=256) -> error=1, pc_reset=1, no strobe.
REQ-037 SHALL cover: in_valid gaps between bytes -> identical writes; gap > TIMEOUT_CYCLES -> error=1.
REQ-038 SHALL cover: reset_n pulsed low after the first word -> outputs immediately return to reset values, and no further strobes occur.
REQ-039 SHALL cover, with BOOT_CHECKSUM_EN: stream 00 01 12 34 27 -> RUN; stream 00 01 12 34 00 -> ERROR with addr 0 written.
REQ-040 SHALL cover: start in RUN -> pc_reset=1 next cycle and a reload succeeds.

Source files
------------

// File: rtl/cpu_boot_loader.sv
// cpu_boot_loader
//   Receives a byte-stream boot image, writes it into the CPU instruction
//   memory one 16-bit word at a time, then releases the CPU from reset.
//   Stream format: word count N (MSB byte first), then N words (high byte
//   first). When BOOT_CHECKSUM_EN is defined, one more byte follows: the
//   XOR of every preceding stream byte, including the two length bytes.
//
// Compile-time option:
//   BOOT_CHECKSUM_EN  adds the CHECK state that verifies the trailing checksum
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 one-cycle load request (honoured in IDLE/RUN/ERROR)
//   in_data/in_valid/in_ready   byte stream handshake
//   instruction_in, load_address, load_instruction   instruction-memory write
//   pc_reset              CPU hold (CPU runs only while 0)
//   busy, done, error     status flags
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LEN_HI  | receiving word-count MSB
// LEN_LO  | receiving word-count LSB, range-checked on acceptance
// DATA_HI | receiving instruction high byte
// DATA_LO | receiving instruction low byte
// WRITE   | one-cycle instruction-memory write strobe
// CHECK   | receiving checksum byte (BOOT_CHECKSUM_EN only)
// RUN     | image loaded, CPU released
// ERROR   | bad length, checksum or timeout; CPU held
module cpu_boot_loader #(
  parameter int MEM_DEPTH      = 256,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] instruction_in,
  output logic [15:0] load_address,
  output logic        load_instruction,
  output logic        pc_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   DEPTH17   = 17'(MEM_DEPTH);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN, ERROR
  } state_t;

  state_t        r_state, r_state_nxt;
  logic [15:0]   r_len;
  logic [15:0]   r_addr;
  logic [15:0]   r_word;
  logic [IW-1:0] r_idle;

  logic        w_accept;
  logic        w_start_ok;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic [15:0] w_addr_inc;
  logic        w_timeout;

  assign in_ready = (r_state == LEN_HI) || (r_state == LEN_LO) ||
                    (r_state == DATA_HI) || (r_state == DATA_LO) ||
                    (r_state == CHECK);
  assign w_accept   = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == RUN) || (r_state == ERROR));
  assign w_len      = {r_len[15:8], in_data};
  assign w_len_bad  = (w_len == 16'd0) || ({1'b0, w_len} > DEPTH17);
  assign w_addr_inc = r_addr + 16'd1;
  // Counter holds the number of consecutive stalled receiving cycles so far;
  // this cycle would be number TIMEOUT_CYCLES.
  assign w_timeout  = in_ready && !w_accept && (r_idle == IDLE_LAST);

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] r_csum;
`endif

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      IDLE, RUN, ERROR: if (start) r_state_nxt = LEN_HI;
      LEN_HI:  if (w_accept) r_state_nxt = LEN_LO;
      LEN_LO:  if (w_accept) r_state_nxt = w_len_bad ? ERROR : DATA_HI;
      DATA_HI: if (w_accept) r_state_nxt = DATA_LO;
      DATA_LO: if (w_accept) r_state_nxt = WRITE;
      WRITE: begin
        if (w_addr_inc < r_len) r_state_nxt = DATA_HI;
`ifdef BOOT_CHECKSUM_EN
        else                    r_state_nxt = CHECK;
`else
        else                    r_state_nxt = RUN;
`endif
      end
`ifdef BOOT_CHECKSUM_EN
      CHECK: if (w_accept) r_state_nxt = (in_data == r_csum) ? RUN : ERROR;
`endif
      default: r_state_nxt = IDLE;
    endcase
    if (w_timeout) r_state_nxt = ERROR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_len   <= 16'd0;
      r_addr  <= 16'd0;
      r_word  <= 16'd0;
      r_idle  <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (!in_ready || w_accept) r_idle <= '0;
      else                       r_idle <= r_idle + IW'(1);
      if (w_accept && r_state == LEN_HI)  r_len[15:8]  <= in_data;
      if (w_accept && r_state == LEN_LO)  r_len[7:0]   <= in_data;
      if (w_accept && r_state == LEN_LO)  r_addr       <= 16'd0;
      if (r_state == WRITE)               r_addr       <= w_addr_inc;
      if (w_accept && r_state == DATA_HI) r_word[15:8] <= in_data;
      if (w_accept && r_state == DATA_LO) r_word[7:0]  <= in_data;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        r_csum <= 8'd0;
    else if (w_start_ok)                 r_csum <= 8'd0;
    else if (w_accept && r_state != CHECK) r_csum <= r_csum ^ in_data;
  end
`endif

  assign load_instruction = (r_state == WRITE);
  assign instruction_in   = r_word;
  assign load_address     = r_addr;
  assign pc_reset         = (r_state != RUN);
  assign done             = (r_state == RUN);
  assign error            = (r_state == ERROR);
  assign busy             = !((r_state == IDLE) || (r_state == RUN) || (r_state == ERROR));

endmodule

// File: tb/tb_cpu_boot_loader.sv
module tb_cpu_boot_loader;
  localparam int DEPTH = 256;
  localparam int TMO   = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instruction_in;
  logic [15:0] load_address;
  logic        load_instruction;
  logic        pc_reset, busy, done, error;

  cpu_boot_loader #(.MEM_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .instruction_in(instruction_in),
    .load_address(load_address), .load_instruction(load_instruction),
    .pc_reset(pc_reset), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_strobe = 0;
  int prev_strobe = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] wq[$];
  logic [31:0] mon_e;

  always @(posedge clk) cyc++;

  // Scoreboard: every write strobe must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (load_instruction === 1'b1) begin
      strobe_cnt++;
      prev_strobe = last_strobe;
      last_strobe = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe got addr=%h data=%h expected none", load_address, instruction_in);
      end else begin
        mon_e = exp_q.pop_front();
        if ({load_address, instruction_in} !== mon_e) begin
          errors++;
          $display("FAIL strobe got %h expected %h", {load_address, instruction_in}, mon_e);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin in_data = 8'($urandom); @(negedge clk); end
    in_data = b; in_valid = 1'b1; n = 0;
    while (in_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL byte_accept got in_ready=%b expected 1 within 100 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'($urandom);
  endtask

  task automatic send_tx(input int gap);
    foreach (tx_q[i]) send_byte(tx_q[i], gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Builds tx_q from wq: length, words, and (with checksum) the XOR byte.
  task automatic build_tx(input logic [15:0] n, input bit push_exp);
    logic [7:0] x;
    tx_q = {n[15:8], n[7:0]};
    foreach (wq[i]) begin
      tx_q.push_back(wq[i][15:8]);
      tx_q.push_back(wq[i][7:0]);
      if (push_exp) exp_q.push_back({16'(i), wq[i]});
    end
`ifdef BOOT_CHECKSUM_EN
    x = 8'd0;
    foreach (tx_q[i]) x = x ^ tx_q[i];
    tx_q.push_back(x);
`else
    x = 8'd0;
`endif
  endtask

  task automatic wait_end();
    int n = 0;
    while (done !== 1'b1 && error !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_end got done=%b error=%b expected one set within 50 cycles", done, error);
    end
  endtask

  task automatic check_ok(input string name);
    checks++;
    if ({done, error, pc_reset, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_run got done/err/pc/busy=%b expected 1000", name, {done, error, pc_reset, busy});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d writes left expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_err(input string name, input int strobes_before);
    checks++;
    if ({done, error, pc_reset, busy} !== 4'b0110) begin
      errors++;
      $display("FAIL %s_err got done/err/pc/busy=%b expected 0110", name, {done, error, pc_reset, busy});
    end
    checks++;
    if (strobe_cnt != strobes_before) begin
      errors++;
      $display("FAIL %s_strobes got %0d expected %0d", name, strobe_cnt, strobes_before);
    end
  endtask

  task automatic check_reset_vals(input string name);
    checks++;
    if ({pc_reset, load_instruction, in_ready, busy, done, error, instruction_in, load_address}
        !== {6'b100000, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL %s got %b_%h_%h expected 100000_0000_0000", name,
               {pc_reset, load_instruction, in_ready, busy, done, error}, instruction_in, load_address);
    end
  endtask

  task automatic test_reset();
    #1 check_reset_vals("reset_t0");
    repeat (3) @(negedge clk);
    check_reset_vals("reset_held");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset_released");
  endtask

  task automatic test_basic();
    wq = {16'h1234, 16'hABCD};
    build_tx(16'd2, 1'b1);
    do_start();
    checks++;
    if ({pc_reset, busy, in_ready} !== 3'b111) begin
      errors++; $display("FAIL start_len_hi got %b expected 111", {pc_reset, busy, in_ready});
    end
    send_tx(0);
    wait_end();
    check_ok("basic");
    checks++;
    if (last_strobe - prev_strobe != 3) begin
      errors++; $display("FAIL throughput got %0d cycles expected 3", last_strobe - prev_strobe);
    end
  endtask

  task automatic test_len_errors();
    logic [15:0] bad[2] = '{16'h0000, 16'h0101};
    int s;
    foreach (bad[i]) begin
      s = strobe_cnt;
      do_start();
      tx_q = {bad[i][15:8], bad[i][7:0]};
      send_tx(0);
      wait_end();
      check_err("len_bad", s);
    end
  endtask

  task automatic test_max_len();
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back(16'($urandom));
    build_tx(16'(DEPTH), 1'b1);
    do_start();
    send_tx(0);
    wait_end();
    check_ok("max_len");
  endtask

  task automatic test_gaps();
    int s;
    wq = {16'hBEEF, 16'h0001, 16'h8000};
    build_tx(16'd3, 1'b1);
    do_start();
    send_tx(3);
    wait_end();
    check_ok("gaps");
    s = strobe_cnt;
    do_start();
    tx_q = {8'h00, 8'h02, 8'h12};
    send_tx(0);
    in_valid = 1'b0;
    repeat (TMO + 5) @(negedge clk);
    check_err("timeout", s);
  endtask

  task automatic test_back_to_back();
    wq = {16'hCAFE, 16'h5A5A};
    build_tx(16'd2, 1'b1);
    do_start();
    send_byte(tx_q[0], 0);
    send_byte(tx_q[1], 0);
    do_start();
    for (int i = 2; i < tx_q.size(); i++) send_byte(tx_q[i], 0);
    wait_end();
    check_ok("ignore_start");
    do_start();
    checks++;
    if ({pc_reset, done, busy} !== 3'b101) begin
      errors++; $display("FAIL restart got pc/done/busy=%b expected 101", {pc_reset, done, busy});
    end
    wq = {16'h0F0F, 16'hF0F0, 16'h7777};
    build_tx(16'd3, 1'b1);
    send_tx(1);
    wait_end();
    check_ok("reload");
  endtask

  task automatic test_reset_mid();
    int s;
    wq = {16'h1234, 16'hABCD};
    build_tx(16'd2, 1'b0);
    exp_q.push_back({16'd0, 16'h1234});
    do_start();
    for (int i = 0; i < 5; i++) send_byte(tx_q[i], 0);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    s = strobe_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    in_valid = 1'b1;
    repeat (10) begin in_data = 8'($urandom); @(negedge clk); end
    in_valid = 1'b0;
    checks++;
    if ({busy, pc_reset, strobe_cnt == s} !== 3'b011) begin
      errors++; $display("FAIL after_reset got busy/pc/no_strobe=%b expected 011", {busy, pc_reset, strobe_cnt == s});
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL reset_mid_first_word got %0d pending expected 0", exp_q.size());
    end
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    int s;
    exp_q.push_back({16'd0, 16'h1234});
    tx_q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h27};
    do_start();
    send_tx(0);
    wait_end();
    check_ok("csum_good");
    exp_q.push_back({16'd0, 16'h1234});
    tx_q = {8'h00, 8'h01, 8'h12, 8'h34, 8'h00};
    do_start();
    send_tx(0);
    s = strobe_cnt;
    wait_end();
    check_err("csum_bad", s);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL csum_bad_write got %0d pending expected 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_len_errors();
    test_max_len();
    test_gaps();
    test_back_to_back();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
